// File: rtl/sys_mem_sram_cntrlr.sv
// SRAM responder for the sys_mem arbiter: each 32-bit word request is executed
// as two sequential 16-bit accesses (low half, then high half) on an async SRAM.
module sys_mem_sram_cntrlr #(
    parameter int unsigned MEM_ADDR_W  = 27,
    parameter int unsigned MEM_DATA_W  = 32,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned SRAM_DATA_W = 16,
    parameter int unsigned ACC_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   cntrlr_wait,
    input  logic                   cntrlr_wren,
    input  logic                   cntrlr_rden,
    input  logic [MEM_ADDR_W-1:0]  cntrlr_addr,
    input  logic [MEM_DATA_W-1:0]  cntrlr_wdata,
    output logic                   cntrlr_rd_valid,
    output logic [MEM_DATA_W-1:0]  cntrlr_rdata,
    output logic                   cmd_err,
    input  logic                   cmd_err_clr,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_lb_n,
    output logic                   sram_ub_n
);

    localparam int unsigned PC_W = 4;
    localparam int unsigned HA_W = SRAM_ADDR_W - 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(ACC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI
    } state_t;

    state_t                 state;
    logic [PC_W-1:0]        pc;
    logic [HA_W-1:0]        addr_q;
    logic [MEM_DATA_W-1:0]  wdata_q;
    logic [SRAM_DATA_W-1:0] rd_lo;

    logic            last_c;
    logic [PC_W-1:0] pc_inc_c;
    logic            req_c;
    logic            unused_addr_bits;

    assign last_c   = (pc == PC_LAST);
    assign pc_inc_c = pc + PC_W'(1);
    assign req_c    = cntrlr_wren | cntrlr_rden;

    // Word address bits above the SRAM halfword range are ignored.
    assign unused_addr_bits = ^cntrlr_addr[MEM_ADDR_W-1:HA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_lo           <= '0;
            cntrlr_wait     <= 1'b0;
            cntrlr_rd_valid <= 1'b0;
            cntrlr_rdata    <= '0;
            cmd_err         <= 1'b0;
            sram_addr       <= '0;
            sram_dq_out     <= '0;
            sram_dq_oe      <= 1'b0;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_lb_n       <= 1'b1;
            sram_ub_n       <= 1'b1;
        end else begin
            cntrlr_rd_valid <= 1'b0;

            // Clear wins over a simultaneous conflicting request.
            if (cmd_err_clr)
                cmd_err <= 1'b0;
            else if (state == IDLE && cntrlr_wren && cntrlr_rden)
                cmd_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (req_c) begin
                        addr_q      <= cntrlr_addr[HA_W-1:0];
                        wdata_q     <= cntrlr_wdata;
                        pc          <= '0;
                        cntrlr_wait <= 1'b1;
                        sram_addr   <= {cntrlr_addr[HA_W-1:0], 1'b0};
                        sram_ce_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                        sram_ub_n   <= 1'b0;
                        if (cntrlr_wren) begin
                            state       <= WR_LO;
                            sram_dq_out <= cntrlr_wdata[SRAM_DATA_W-1:0];
                            sram_dq_oe  <= 1'b1;
                            sram_we_n   <= 1'b0;
                            sram_oe_n   <= 1'b1;
                        end else begin
                            state      <= RD_LO;
                            sram_dq_oe <= 1'b0;
                            sram_we_n  <= 1'b1;
                            sram_oe_n  <= 1'b0;
                        end
                    end else begin
                        cntrlr_wait <= 1'b0;
                        sram_dq_oe  <= 1'b0;
                        sram_ce_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b1;
                        sram_lb_n   <= 1'b1;
                        sram_ub_n   <= 1'b1;
                    end
                end

                WR_LO: begin
                    if (last_c) begin
                        state       <= WR_HI;
                        pc          <= '0;
                        sram_addr   <= {addr_q, 1'b1};
                        sram_dq_out <= wdata_q[MEM_DATA_W-1:SRAM_DATA_W];
                        sram_we_n   <= 1'b0;
                    end else begin
                        pc        <= pc_inc_c;
                        sram_we_n <= (pc_inc_c == PC_LAST);
                    end
                end

                WR_HI: begin
                    if (last_c) begin
                        state       <= IDLE;
                        pc          <= '0;
                        cntrlr_wait <= 1'b0;
                        sram_dq_oe  <= 1'b0;
                        sram_ce_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b1;
                        sram_lb_n   <= 1'b1;
                        sram_ub_n   <= 1'b1;
                    end else begin
                        pc        <= pc_inc_c;
                        sram_we_n <= (pc_inc_c == PC_LAST);
                    end
                end

                RD_LO: begin
                    if (last_c) begin
                        state     <= RD_HI;
                        pc        <= '0;
                        rd_lo     <= sram_dq_in;
                        sram_addr <= {addr_q, 1'b1};
                    end else begin
                        pc <= pc_inc_c;
                    end
                end

                RD_HI: begin
                    if (last_c) begin
                        state           <= IDLE;
                        pc              <= '0;
                        cntrlr_rdata    <= {sram_dq_in, rd_lo};
                        cntrlr_rd_valid <= 1'b1;
                        cntrlr_wait     <= 1'b0;
                        sram_ce_n       <= 1'b1;
                        sram_oe_n       <= 1'b1;
                        sram_we_n       <= 1'b1;
                        sram_lb_n       <= 1'b1;
                        sram_ub_n       <= 1'b1;
                    end else begin
                        pc <= pc_inc_c;
                    end
                end

                default: begin
                    state       <= IDLE;
                    pc          <= '0;
                    cntrlr_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_mem_sram_cntrlr.sv
// Directed bench for sys_mem_sram_cntrlr: default build plus an ACC_CYCLES=4 build,
// each backed by a simple halfword SRAM model.
module tb_sys_mem_sram_cntrlr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default (ACC_CYCLES=2) instance
    logic        wren, rden, clr, busy, rd_valid, cmd_err;
    logic [26:0] addr;
    logic [31:0] wdata, rdata;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;
    logic [15:0] mem [0:1023];

    // ACC_CYCLES=4 instance
    logic        wren4, rden4, clr4, busy4, rd_valid4, cmd_err4;
    logic [26:0] addr4;
    logic [31:0] wdata4, rdata4;
    logic [17:0] sram_addr4;
    logic [15:0] dq_out4, dq_in4;
    logic        dq_oe4, ce_n4, oe_n4, we_n4, lb_n4, ub_n4;
    logic [15:0] mem4 [0:1023];

    sys_mem_sram_cntrlr dut (
        .clk(clk), .rst(rst), .cntrlr_wait(busy), .cntrlr_wren(wren), .cntrlr_rden(rden),
        .cntrlr_addr(addr), .cntrlr_wdata(wdata), .cntrlr_rd_valid(rd_valid), .cntrlr_rdata(rdata),
        .cmd_err(cmd_err), .cmd_err_clr(clr), .sram_addr(sram_addr), .sram_dq_out(dq_out),
        .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
        .sram_we_n(we_n), .sram_lb_n(lb_n), .sram_ub_n(ub_n)
    );

    sys_mem_sram_cntrlr #(.ACC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .cntrlr_wait(busy4), .cntrlr_wren(wren4), .cntrlr_rden(rden4),
        .cntrlr_addr(addr4), .cntrlr_wdata(wdata4), .cntrlr_rd_valid(rd_valid4), .cntrlr_rdata(rdata4),
        .cmd_err(cmd_err4), .cmd_err_clr(clr4), .sram_addr(sram_addr4), .sram_dq_out(dq_out4),
        .sram_dq_oe(dq_oe4), .sram_dq_in(dq_in4), .sram_ce_n(ce_n4), .sram_oe_n(oe_n4),
        .sram_we_n(we_n4), .sram_lb_n(lb_n4), .sram_ub_n(ub_n4)
    );

    // SRAM models: write while we_n is low, combinational read while oe_n is low
    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) mem[sram_addr[9:0]] <= dq_out;
        if (!ce_n4 && !we_n4 && dq_oe4) mem4[sram_addr4[9:0]] <= dq_out4;
    end
    assign dq_in  = (!ce_n && !oe_n) ? mem[sram_addr[9:0]] : 16'h0000;
    assign dq_in4 = (!ce_n4 && !oe_n4) ? mem4[sram_addr4[9:0]] : 16'h0000;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_read(input logic [26:0] a, output logic [31:0] d, output int lat);
        d   = '0;
        lat = -1;
        addr = a;
        rden = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            rden = 1'b0;
            if (rd_valid && lat < 0) begin
                d   = rdata;
                lat = c;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nwait, nwe, nrv, rv_cyc, noe, noe_drv, lat, op, cyc, nwe_lo, nwe_hi;
        int acc [3];
        logic [31:0] rdat;
        logic [31:0] rv [4];
        logic        op_wr [3];
        logic [31:0] op_data [3];

        rst = 1'b1;
        {wren, rden, clr, addr, wdata} = '0;
        {wren4, rden4, clr4, addr4, wdata4} = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_wait", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq_out", dq_out, 0);
        check("rst_dq_oe", dq_oe, 0);
        check("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        check("rst_strobes4", {ce_n4, oe_n4, we_n4, lb_n4, ub_n4}, 5'b11111);
        rst = 1'b0;
        @(negedge clk);

        // Write 0xDEADBABE to word 5
        addr = 27'h5; wdata = 32'hDEADBABE; wren = 1'b1;
        nwait = 0; nwe = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            wren = 1'b0;
            if (busy) nwait++;
            if (!we_n) nwe++;
            if (c == 1) begin
                check("wr_lo_addr", sram_addr, 18'h0000A);
                check("wr_lo_dq", dq_out, 16'hBABE);
                check("wr_lo_oe", dq_oe, 1);
                check("wr_lo_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b01000);
            end
            if (c == 2) check("wr_lo_hold", {we_n, sram_addr}, {1'b1, 18'h0000A});
            if (c == 3) begin
                check("wr_hi_addr", sram_addr, 18'h0000B);
                check("wr_hi_dq", dq_out, 16'hDEAD);
                check("wr_hi_we", we_n, 0);
            end
        end
        check("wr_wait_cycles", nwait, 4);
        check("wr_we_cycles", nwe, 2);
        check("wr_mem_lo", mem[10], 16'hBABE);
        check("wr_mem_hi", mem[11], 16'hDEAD);

        // Read word 5
        addr = 27'h5; rden = 1'b1;
        nrv = 0; rv_cyc = 0; noe = 0; noe_drv = 0; rdat = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rden = 1'b0;
            if (rd_valid) begin nrv++; rv_cyc = c; rdat = rdata; end
            if (!oe_n) noe++;
            if (dq_oe) noe_drv++;
        end
        check("rd_valid_cycle", rv_cyc, 5);
        check("rd_valid_pulses", nrv, 1);
        check("rd_data", rdat, 32'hDEADBABE);
        check("rd_oe_cycles", noe, 4);
        check("rd_dq_oe", noe_drv, 0);
        check("rd_rdata_hold", rdata, 32'hDEADBABE);

        // Back-to-back read, write, read with requests held continuously
        op_wr[0] = 1'b0; op_data[0] = 32'h0;
        op_wr[1] = 1'b1; op_data[1] = 32'hCAFEF00D;
        op_wr[2] = 1'b0; op_data[2] = 32'h0;
        op = 0; nrv = 0; cyc = 0;
        acc[0] = -1; acc[1] = -1; acc[2] = -1;
        repeat (30) begin
            if (rd_valid) begin
                if (nrv < 4) rv[nrv] = rdata;
                nrv++;
            end
            if (op < 3) begin
                addr = 27'h5; wdata = op_data[op]; wren = op_wr[op]; rden = !op_wr[op];
                if (!busy) begin acc[op] = cyc; op++; end
            end else begin
                wren = 1'b0; rden = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_accepts", op, 3);
        check("b2b_gap01", acc[1] - acc[0], 5);
        check("b2b_gap12", acc[2] - acc[1], 5);
        check("b2b_reads", nrv, 2);
        check("b2b_rd0", rv[0], 32'hDEADBABE);
        check("b2b_rd1", rv[1], 32'hCAFEF00D);

        // Conflicting request executes as a write and sets cmd_err
        addr = 27'h3; wdata = 32'h12345678; wren = 1'b1; rden = 1'b1;
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        check("err_set", cmd_err, 1);
        check("err_is_write", {dq_oe, oe_n}, 2'b11);
        check("err_addr", sram_addr, 18'h00006);
        check("err_dq", dq_out, 16'h5678);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        check("err_done", busy, 0);
        check("err_mem_lo", mem[6], 16'h5678);
        check("err_mem_hi", mem[7], 16'h1234);
        check("err_sticky", cmd_err, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("err_clr", cmd_err, 0);

        // Clear dominates a simultaneous set
        wren = 1'b1; rden = 1'b1; clr = 1'b1;
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; clr = 1'b0;
        check("err_clr_wins", cmd_err, 0);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);

        // Reset during RD_HI abandons the read
        addr = 27'h5; rden = 1'b1;
        repeat (3) begin @(negedge clk); rden = 1'b0; end
        check("rst_mid_in_rd_hi", {oe_n, sram_addr}, {1'b0, 18'h0000B});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nrv = 0;
        if (rd_valid) nrv++;
        @(negedge clk);
        check("rst_mid_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        check("rst_mid_wait", busy, 0);
        repeat (6) begin
            if (rd_valid) nrv++;
            @(negedge clk);
        end
        check("rst_mid_no_valid", nrv, 0);
        do_read(27'h5, rdat, lat);
        check("rst_after_rd_data", rdat, 32'hCAFEF00D);
        check("rst_after_rd_lat", lat, 5);

        // ACC_CYCLES=4 build: write then read
        addr4 = 27'h2; wdata4 = 32'hA5A55A5A; wren4 = 1'b1;
        nwait = 0; nwe_lo = 0; nwe_hi = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            wren4 = 1'b0;
            if (busy4) nwait++;
            if (!we_n4 && sram_addr4 == 18'h4) nwe_lo++;
            if (!we_n4 && sram_addr4 == 18'h5) nwe_hi++;
        end
        check("acc4_wait_cycles", nwait, 8);
        check("acc4_we_lo", nwe_lo, 3);
        check("acc4_we_hi", nwe_hi, 3);
        check("acc4_mem", {mem4[5], mem4[4]}, 32'hA5A55A5A);
        rden4 = 1'b1;
        rv_cyc = 0; rdat = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rden4 = 1'b0;
            if (rd_valid4 && rv_cyc == 0) begin rv_cyc = c; rdat = rdata4; end
        end
        check("acc4_rd_cycle", rv_cyc, 9);
        check("acc4_rd_data", rdat, 32'hA5A55A5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sys_mem_sram_cntrlr.md
Name: sys_mem_sram_cntrlr

Overview:
- Memory-side responder for the sys_mem arbiter controller interface (cntrlr_wait/wren/rden/addr/wdata/rd_valid/rdata).
- Accepts one 32-bit word transaction at a time and executes it as two sequential 16-bit accesses (low half, then high half) on an external asynchronous SRAM.
- Returns read data with a single-cycle valid pulse.
- Sits between sys_mem_arb and the board SRAM pins; tristate resolution is done at the top level.

Parameters:
- MEM_ADDR_W, 27, word address width of the controller interface.
- MEM_DATA_W, 32, word data width; fixed at 2*SRAM_DATA_W.
- SRAM_ADDR_W, 18, SRAM halfword address width.
- SRAM_DATA_W, 16, SRAM data width.
- ACC_CYCLES, 2, clocks per halfword access; legal range is 2 to 15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cntrlr_wait  out  1  high while busy; a request is accepted only in a cycle where this is low
- cntrlr_wren  in  1  write request
- cntrlr_rden  in  1  read request
- cntrlr_addr  in  MEM_ADDR_W  word address
- cntrlr_wdata  in  MEM_DATA_W  write data
- cntrlr_rd_valid  out  1  read data valid pulse
- cntrlr_rdata  out  MEM_DATA_W  read data
- cmd_err  out  1  sticky: wren and rden were both seen in an accepting cycle
- cmd_err_clr  in  1  clears cmd_err
- sram_addr  out  SRAM_ADDR_W  halfword address
- sram_dq_out  out  SRAM_DATA_W  write data
- sram_dq_oe  out  1  drive enable for sram_dq_out
- sram_dq_in  in  SRAM_DATA_W  read data from pins
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - State IDLE; cntrlr_wait=0; cntrlr_rd_valid=0; cntrlr_rdata=0; cmd_err=0.
  - sram_addr=0; sram_dq_out=0; sram_dq_oe=0.
  - All sram_*_n=1.
- Reset mid-operation: the transaction is abandoned with no rd_valid, and all strobes are inactive from the next cycle.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI. A phase counter pc counts 0 to ACC_CYCLES-1 in each non-IDLE state.
- cntrlr_wait is registered and is 1 exactly when the next state is not IDLE.
- Accept condition: (cntrlr_wren | cntrlr_rden) while in IDLE, at which point cntrlr_addr and cntrlr_wdata are latched.
  - wren has priority: a request with both wren and rden is executed as a write and sets cmd_err.
  - cmd_err_clr dominates a simultaneous set.
- Address mapping: sram_addr = {cntrlr_addr[SRAM_ADDR_W-2:0], half}, with half=0 in *_LO and 1 in *_HI. Upper address bits are ignored.
- Transitions:
  - IDLE -> WR_LO or RD_LO on accept.
  - *_LO -> *_HI when pc==ACC_CYCLES-1.
  - *_HI -> IDLE when pc==ACC_CYCLES-1.
  - pc resets to 0 on each state entry.
- Strobes in any non-IDLE state: sram_ce_n=0, sram_lb_n=0, sram_ub_n=0, and sram_addr stable for the whole phase.
- Write phase:
  - sram_dq_oe=1; sram_dq_out = wdata[15:0] in WR_LO and wdata[31:16] in WR_HI.
  - sram_we_n=0 for pc<ACC_CYCLES-1 and sram_we_n=1 on the last cycle (hold); sram_oe_n=1.
- Read phase:
  - sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - sram_dq_in is captured at pc==ACC_CYCLES-1: into the low half register in RD_LO, and into the high half in RD_HI.
- Read response: on the RD_HI -> IDLE edge, cntrlr_rdata={hi,lo} and cntrlr_rd_valid=1 for exactly one cycle. cntrlr_rdata holds its value until the next read completes.
- Timing (request accepted at edge E0):
  - cntrlr_wait is high for cycles 1 to 2*ACC_CYCLES.
  - cntrlr_wait is low again in cycle 2*ACC_CYCLES+1.
  - Read rd_valid is high in cycle 2*ACC_CYCLES+1, i.e. 5 cycles for the default.
- Back-to-back: a new request may be accepted in the same cycle that rd_valid is high. Throughput is one word per 2*ACC_CYCLES+1 cycles.
- IDLE with no request: no strobes asserted, and sram_addr/sram_dq_out hold their previous values.

Test Plan:
- Reset, then write addr=0x0000005, wdata=0xDEADBABE -> sram_addr 0x0000A then 0x0000B; dq_out 0xBABE then 0xDEAD; we_n low 1 cycle per phase; wait high 4 cycles.
- Read addr=0x5 with the SRAM model holding 0xBABE at 0xA and 0xDEAD at 0xB -> rd_valid single pulse 5 cycles after accept with rdata=0xDEADBABE; oe_n low 4 cycles; dq_oe=0 throughout.
- Back-to-back read, write, read with requests held continuously -> each accepted exactly in a wait=0 cycle, no request lost or duplicated, second read returns the newly written data.
- wren=rden=1 at addr 0x3, wdata=0x12345678 -> executed as write, cmd_err=1; pulse cmd_err_clr -> cmd_err=0 next cycle.
- Assert rst during RD_HI -> no rd_valid, all strobes 1 and wait=0 the cycle after reset releases; a subsequent read of addr 0x5 returns correct data.
- ACC_CYCLES=4 build: write -> we_n low 3 cycles per phase; read -> rd_valid 9 cycles after accept.
